serial_disp_sched: RTL
======================

// Module: serial_disp_sched
// PURPOSE
//  Scheduler for the board's two serial display chains: 7-seg (seg_clk/do/pen) and LED (led_clk/do/pen).
//  A single bit-serial shift engine is shared between the two.
//  Accepts update requests from the CPU-side I/O registers and arbitrates round-robin between them.
//  Shifts the snapshotted pattern MSB-first, then pulses the chain latch.
//  Sits in top between the MMIO register block and the board pins.
// PARAMETERS
//  DIV       4   clk_100mhz cycles per half serial-clock period (>=1)
//  SEG_BITS  64  7-seg chain length in bits
//  LED_BITS  16  LED chain length in bits
// PORTS
//  clk_100mhz  in   1         system clock; all logic on rising edge
//  RSTN        in   1         synchronous reset, active-low
//  seg_data    in   SEG_BITS  7-seg pattern, sampled at grant
//  seg_req     in   1         1-cycle pulse: refresh 7-seg chain
//  led_data    in   LED_BITS  LED pattern, sampled at grant
//  led_req     in   1         1-cycle pulse: refresh LED chain
//  seg_ack     out  1         1-cycle pulse when 7-seg transfer latched
//  led_ack     out  1         1-cycle pulse when LED transfer latched
//  busy        out  1         engine not IDLE
//  seg_clk     out  1         7-seg serial clock
//  seg_do      out  1         7-seg serial data
//  seg_pen     out  1         7-seg latch enable
//  led_clk     out  1         LED serial clock
//  led_do      out  1         LED serial data
//  led_pen     out  1         LED latch enable
// BEHAVIOUR
//  Reset (RSTN=0 at edge): state IDLE, pending flags 0, last_grant=LED; all *_clk=0, *_do=0, *_pen=1, acks=0, busy=0.
//  Reset mid-transfer aborts immediately; a partially shifted chain is not latched (pen stays 1).
//  Request capture: *_req sets pending_x on every cycle incl. while busy. Repeated requests coalesce into one flag.
//  pending_x clears at the grant cycle. A req arriving in the grant cycle itself re-sets it (req wins).
//  Arbitration (IDLE only): exactly one pending -> grant it.
//   Both pending -> grant the channel not in last_grant. last_grant updates at grant.
//  FSM: IDLE -> LOAD -> SHIFT -> LATCH -> IDLE.
//  LOAD (1 cycle): shift register <= selected data.
//   Bit counter <= N-1 (N=SEG_BITS or LED_BITS).
//   Selected pen <= 0; busy=1.
//  SHIFT: per bit, do=current MSB for 2*DIV cycles.
//   clk=0 for the first DIV cycles, 1 for the next DIV cycles; rising edge is mid-bit.
//   At end of the bit, clk->0, the register shifts left and the counter decrements.
//   After bit 0 -> LATCH.
//  LATCH (DIV cycles): do=0, clk=0.
//   On the last cycle, pen returns to 1 (rising edge latches chain), ack pulses 1 cycle, and next state is IDLE.
//  Unselected chain outputs hold idle values (clk=0, do=0, pen=1) throughout.
//  Latency req->ack (idle engine, no contention): 1 capture + 1 LOAD + 2*DIV*N + DIV cycles.
//   With defaults: seg 2+512+4=518, led 2+128+4=134.
//  Back-to-back: from IDLE, a pending request is granted on the cycle after ack (no dead time beyond IDLE cycle).
//  Data inputs are sampled only in LOAD; later changes do not affect the transfer in flight.
// TESTING
//  T1 reset: RSTN=0 during SHIFT of seg -> next cycle seg_pen=1, seg_clk=0, busy=0, no seg_ack.
//  T2 led only: led_data=16'hA5C3, led_req pulse -> 16 rising led_clk edges sampling 1010_0101_1100_0011.
//   led_pen rises and led_ack pulses at cycle 134; seg_* idle.
//  T3 seg only: seg_data=64'h0123_4567_89AB_CDEF -> 64 bits MSB-first on seg_do, seg_ack at cycle 518.
//  T4 contention: seg_req and led_req same cycle after reset -> seg granted first (last_grant=LED).
//   LED starts in the cycle after seg_ack's IDLE cycle; the next simultaneous pair grants LED first.
//  T5 coalesce: 3 seg_req pulses during a seg transfer -> exactly one further seg transfer.
//   Its data is seg_data sampled at that LOAD.
//  T6 DIV=1 build: led transfer -> led_clk toggles every cycle, led_ack at 1+1+32+1=35 cycles.

Source files
------------

// File: rtl/serial_disp_sched.sv
// rtl/serial_disp_sched.sv - shared bit-serial engine refreshing the 7-seg and LED display chains
module serial_disp_sched #(
    parameter int DIV      = 4,
    parameter int SEG_BITS = 64,
    parameter int LED_BITS = 16
) (
    input  logic                clk_100mhz,
    input  logic                RSTN,
    input  logic [SEG_BITS-1:0] seg_data,
    input  logic                seg_req,
    input  logic [LED_BITS-1:0] led_data,
    input  logic                led_req,
    output logic                seg_ack,
    output logic                led_ack,
    output logic                busy,
    output logic                seg_clk,
    output logic                seg_do,
    output logic                seg_pen,
    output logic                led_clk,
    output logic                led_do,
    output logic                led_pen
);

    localparam int MAXB = (SEG_BITS > LED_BITS) ? SEG_BITS : LED_BITS;
    localparam int CW   = ($clog2(MAXB) < 1) ? 1 : $clog2(MAXB);
    localparam int DW   = $clog2(2 * DIV);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;           // 1 = LED chain owns the engine
    logic            last_q, last_d;         // 1 = LED was granted last
    logic            seg_pend_q, seg_pend_d;
    logic            led_pend_q, led_pend_d;
    logic [MAXB-1:0] sreg_q, sreg_d;
    logic [CW-1:0]   bcnt_q, bcnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic            seg_pen_q, seg_pen_d;
    logic            led_pen_q, led_pen_d;
    logic            seg_ack_q, seg_ack_d;
    logic            led_ack_q, led_ack_d;
    logic            grant_seg, grant_led;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        sreg_d    = sreg_q;
        bcnt_d    = bcnt_q;
        dcnt_d    = dcnt_q;
        seg_pen_d = seg_pen_q;
        led_pen_d = led_pen_q;
        seg_ack_d = 1'b0;
        led_ack_d = 1'b0;
        grant_seg = 1'b0;
        grant_led = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Round-robin: on contention the channel not served last wins.
                if (seg_pend_q && (!led_pend_q || last_q)) begin
                    grant_seg = 1'b1;
                    sel_d     = 1'b0;
                    last_d    = 1'b0;
                    state_d   = S_LOAD;
                end else if (led_pend_q) begin
                    grant_led = 1'b1;
                    sel_d     = 1'b1;
                    last_d    = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                sreg_d = '0;
                if (sel_q) begin
                    sreg_d[MAXB-1 -: LED_BITS] = led_data;
                    bcnt_d    = CW'(LED_BITS - 1);
                    led_pen_d = 1'b0;
                end else begin
                    sreg_d[MAXB-1 -: SEG_BITS] = seg_data;
                    bcnt_d    = CW'(SEG_BITS - 1);
                    seg_pen_d = 1'b0;
                end
                dcnt_d  = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (dcnt_q == DW'(2 * DIV - 1)) begin
                    dcnt_d = '0;
                    sreg_d = sreg_q << 1;
                    if (bcnt_q == '0) begin
                        state_d = S_LATCH;
                    end else begin
                        bcnt_d = bcnt_q - 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (dcnt_q == DW'(DIV - 1)) begin
                    dcnt_d  = '0;
                    state_d = S_IDLE;
                    if (sel_q) begin
                        led_pen_d = 1'b1;
                        led_ack_d = 1'b1;
                    end else begin
                        seg_pen_d = 1'b1;
                        seg_ack_d = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A request landing in the grant cycle re-arms the flag.
        seg_pend_d = (seg_pend_q & ~grant_seg) | seg_req;
        led_pend_d = (led_pend_q & ~grant_led) | led_req;
    end

    always_ff @(posedge clk_100mhz) begin
        if (!RSTN) begin
            state_q    <= S_IDLE;
            sel_q      <= 1'b0;
            last_q     <= 1'b1;
            seg_pend_q <= 1'b0;
            led_pend_q <= 1'b0;
            sreg_q     <= '0;
            bcnt_q     <= '0;
            dcnt_q     <= '0;
            seg_pen_q  <= 1'b1;
            led_pen_q  <= 1'b1;
            seg_ack_q  <= 1'b0;
            led_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            seg_pend_q <= seg_pend_d;
            led_pend_q <= led_pend_d;
            sreg_q     <= sreg_d;
            bcnt_q     <= bcnt_d;
            dcnt_q     <= dcnt_d;
            seg_pen_q  <= seg_pen_d;
            led_pen_q  <= led_pen_d;
            seg_ack_q  <= seg_ack_d;
            led_ack_q  <= led_ack_d;
        end
    end

    logic shifting, clk_hi;

    // Serial clock is high in the second half of each bit so the rising edge is mid-bit.
    assign shifting = (state_q == S_SHIFT);
    assign clk_hi   = shifting && (dcnt_q >= DW'(DIV));

    assign seg_clk = clk_hi && !sel_q;
    assign led_clk = clk_hi && sel_q;
    assign seg_do  = shifting && !sel_q && sreg_q[MAXB-1];
    assign led_do  = shifting && sel_q && sreg_q[MAXB-1];
    assign seg_pen = seg_pen_q;
    assign led_pen = led_pen_q;
    assign seg_ack = seg_ack_q;
    assign led_ack = led_ack_q;
    assign busy    = (state_q != S_IDLE);

endmodule
